wb_write_buffer: RTL and testbench

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

---
 rtl/wb_write_buffer_pkg.sv | 13 +
 rtl/wb_write_buffer_if.sv | 59 +++++
 rtl/wb_write_buffer_fwd_match.sv | 39 +++
 rtl/wb_write_buffer.sv | 95 +++++++++
 tb/tb_wb_write_buffer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_write_buffer_pkg.sv
// Shared types and constants for the GRF write-back buffer.
package wb_write_buffer_pkg;

    localparam int unsigned WB_DEPTH_DEFAULT = 4;
    localparam logic [4:0]  REG_ZERO         = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_buffer_if.sv
// Bus bundle for the write-back buffer: two request ports, the GRF write port,
// the pending-write lookup and the occupancy status.
interface wb_write_buffer_if
    import wb_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) ();
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [4:0]    a_addr;
    logic [31:0]   a_data;
    logic [31:0]   a_pc;

    logic          b_valid;
    logic          b_ready;
    logic [4:0]    b_addr;
    logic [31:0]   b_data;
    logic [31:0]   b_pc;

    logic          RegWrite;
    logic [4:0]    WriteAddr;
    logic [31:0]   WriteData;
    logic [31:0]   PC;

    logic [4:0]    q1_addr;
    logic [4:0]    q2_addr;
    logic          q1_hit;
    logic          q2_hit;
    logic [31:0]   q1_data;
    logic [31:0]   q2_data;

    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  a_valid, a_addr, a_data, a_pc,
        output a_ready,
        input  b_valid, b_addr, b_data, b_pc,
        output b_ready,
        output RegWrite, WriteAddr, WriteData, PC,
        input  q1_addr, q2_addr,
        output q1_hit, q2_hit, q1_data, q2_data,
        output count, empty
    );

    modport master (
        output a_valid, a_addr, a_data, a_pc,
        input  a_ready,
        output b_valid, b_addr, b_data, b_pc,
        input  b_ready,
        input  RegWrite, WriteAddr, WriteData, PC,
        output q1_addr, q2_addr,
        input  q1_hit, q2_hit, q1_data, q2_data,
        input  count, empty
    );

endinterface

// File: rtl/wb_write_buffer_fwd_match.sv
// wb_fwd_match: finds the youngest live queue entry whose register matches the
// query address; register 0 never matches.
module wb_fwd_match
    import wb_write_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = WB_DEPTH_DEFAULT,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  wb_entry_t        entries [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    head,
    input  logic [4:0]       qaddr,
    output logic             hit,
    output logic [31:0]      data
);
    logic [PW-1:0]    idx;
    logic [DEPTH-1:0] unused_pc;

    // Walk oldest to youngest from the head so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && entries[idx].addr == qaddr && qaddr != REG_ZERO) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

    always_comb begin
        unused_pc = '0;
        for (int unsigned k = 0; k < DEPTH; k++)
            unused_pc[k] = ^entries[k].pc;
    end

endmodule

// File: rtl/wb_write_buffer.sv
// Write-back buffer merging pipeline and multi-cycle results into the GRF port.
// Define WB_FWD_EN to build the pending-write lookup comparators.
module wb_write_buffer
    import wb_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
    input logic              clk,
    input logic              Reset,
    wb_write_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     mem [DEPTH];
    wb_entry_t     head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          a_rdy;
    logic          b_rdy;
    logic          a_push;
    logic          b_push;
    logic          pop;

    // B only gets the slot left over after a nonzero A request; drains earn no credit.
    assign a_rdy  = count_q < CW'(DEPTH);
    assign b_rdy  = (count_q + CW'(bus.a_valid && bus.a_addr != REG_ZERO)) < CW'(DEPTH);
    assign a_push = bus.a_valid && a_rdy && bus.a_addr != REG_ZERO;
    assign b_push = bus.b_valid && b_rdy && bus.b_addr != REG_ZERO;
    assign pop    = count_q != '0;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + PW'(pop);
            wr_ptr  <= wr_ptr + PW'(a_push) + PW'(b_push);
            count_q <= count_q + CW'(a_push) + CW'(b_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (a_push)
            mem[wr_ptr] <= '{addr: bus.a_addr, data: bus.a_data, pc: bus.a_pc};
        if (b_push)
            mem[wr_ptr + PW'(a_push)] <= '{addr: bus.b_addr, data: bus.b_data, pc: bus.b_pc};
    end

    always_comb begin
        head = '0;
        if (pop)
            head = mem[rd_ptr];
    end

    assign bus.a_ready   = a_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.RegWrite  = pop;
    assign bus.WriteAddr = head.addr;
    assign bus.WriteData = head.data;
    assign bus.PC        = head.pc;
    assign bus.count     = count_q;
    assign bus.empty     = count_q == '0;

`ifdef WB_FWD_EN
    logic [DEPTH-1:0] live;

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        live = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            live[i] = {1'b0, PW'(i) - rd_ptr} < count_q;
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_q1 (
        .entries(mem), .valid(live), .head(rd_ptr),
        .qaddr(bus.q1_addr), .hit(bus.q1_hit), .data(bus.q1_data)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_q2 (
        .entries(mem), .valid(live), .head(rd_ptr),
        .qaddr(bus.q2_addr), .hit(bus.q2_hit), .data(bus.q2_data)
    );
`else
    logic unused_qaddr;
    assign unused_qaddr = ^{bus.q1_addr, bus.q2_addr};
    assign bus.q1_hit   = 1'b0;
    assign bus.q2_hit   = 1'b0;
    assign bus.q1_data  = '0;
    assign bus.q2_data  = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_wb_write_buffer;
    import wb_write_buffer_pkg::*;

    localparam int D = 4;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;

    wb_entry_t mq[$];

    wb_write_buffer_if #(.DEPTH(D)) bus ();
    wb_write_buffer_if #(.DEPTH(2)) bus2 ();

    wb_write_buffer #(.DEPTH(D)) dut  (.clk(clk), .Reset(Reset), .bus(bus));
    wb_write_buffer #(.DEPTH(2)) dut2 (.clk(clk), .Reset(Reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_a_ready();
        return mq.size() < D;
    endfunction

    function automatic bit m_b_ready();
        int extra;
        extra = (bus.a_valid && bus.a_addr != 5'd0) ? 1 : 0;
        return (mq.size() + extra) < D;
    endfunction

    function automatic void m_lookup(input logic [4:0] qa, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (FWD && qa != 5'd0)
            foreach (mq[k])
                if (mq[k].addr == qa) begin
                    h = 1'b1;
                    d = mq[k].data;
                end
    endfunction

    task automatic check_all();
        wb_entry_t   h;
        logic        eh;
        logic [31:0] ed;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk("a_ready",   bus.a_ready,   m_a_ready());
        chk("b_ready",   bus.b_ready,   m_b_ready());
        chk("RegWrite",  bus.RegWrite,  mq.size() != 0);
        chk("WriteAddr", bus.WriteAddr, h.addr);
        chk("WriteData", bus.WriteData, h.data);
        chk("PC",        bus.PC,        h.pc);
        chk("count",     bus.count,     mq.size());
        chk("empty",     bus.empty,     mq.size() == 0);
        m_lookup(bus.q1_addr, eh, ed);
        chk("q1_hit",  bus.q1_hit,  eh);
        chk("q1_data", bus.q1_data, ed);
        m_lookup(bus.q2_addr, eh, ed);
        chk("q2_hit",  bus.q2_hit,  eh);
        chk("q2_data", bus.q2_data, ed);
    endtask

    // Model of one rising edge: drain the head, then queue A before B.
    task automatic model_edge();
        bit acc_a, acc_b;
        if (Reset) begin
            mq.delete();
            return;
        end
        acc_a = bus.a_valid && m_a_ready();
        acc_b = bus.b_valid && m_b_ready();
        if (mq.size() != 0) void'(mq.pop_front());
        if (acc_a && bus.a_addr != 5'd0) mq.push_back('{bus.a_addr, bus.a_data, bus.a_pc});
        if (acc_b && bus.b_addr != 5'd0) mq.push_back('{bus.b_addr, bus.b_data, bus.b_pc});
    endtask

    task automatic step();
        #3;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad, input logic [31:0] ap,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic [31:0] bp);
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad; bus.a_pc = ap;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd; bus.b_pc = bp;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, '0, 1'b0, 5'd0, '0, '0);
    endtask

    task automatic idle2();
        bus2.a_valid = 1'b0; bus2.a_addr = 5'd0; bus2.a_data = '0; bus2.a_pc = '0;
        bus2.b_valid = 1'b0; bus2.b_addr = 5'd0; bus2.b_data = '0; bus2.b_pc = '0;
        bus2.q1_addr = 5'd0; bus2.q2_addr = 5'd0;
    endtask

    initial begin
        Reset = 1'b1;
        bus.q1_addr = 5'd0;
        bus.q2_addr = 5'd0;
        idle2();
        drive(1'b1, 5'd9, 32'h99, 32'h10, 1'b1, 5'd10, 32'hAA, 32'h20);
        #1;
        step();
        step();
        chk("rst_RegWrite", bus.RegWrite, 1'b0);
        chk("rst_count",    bus.count,    0);
        chk("rst_empty",    bus.empty,    1'b1);
        chk("rst_a_ready",  bus.a_ready,  1'b1);
        chk("rst_WriteData", bus.WriteData, 32'h0);
        idle();
        Reset = 1'b0;
        step();

        // Single A write reaches the GRF port on the next cycle.
        drive(1'b1, 5'd5, 32'h11111111, 32'h3000, 1'b0, 5'd0, '0, '0);
        step();
        idle();
        chk("w1_RegWrite",  bus.RegWrite,  1'b1);
        chk("w1_WriteAddr", bus.WriteAddr, 5'd5);
        chk("w1_WriteData", bus.WriteData, 32'h11111111);
        chk("w1_PC",        bus.PC,        32'h3000);
        step();
        chk("w1_empty", bus.empty, 1'b1);

        // A and B together: A's entry is written first.
        drive(1'b1, 5'd3, 32'hA, 32'h100, 1'b1, 5'd4, 32'hB, 32'h200);
        step();
        idle();
        chk("ab_count2", bus.count, 2);
        chk("ab_first",  bus.WriteAddr, 5'd3);
        step();
        chk("ab_count1", bus.count, 1);
        chk("ab_second", bus.WriteAddr, 5'd4);
        chk("ab_data2",  bus.WriteData, 32'hB);
        step();
        chk("ab_count0", bus.count, 0);

        // With one pop per cycle the 4-deep queue tops out at 3; the
        // count == DEPTH stall is exercised on a 2-deep instance.
        bus2.a_valid = 1'b1; bus2.a_addr = 5'd1; bus2.a_data = 32'h1;
        bus2.b_valid = 1'b1; bus2.b_addr = 5'd2; bus2.b_data = 32'h2;
        step();
        idle2();
        #1;
        chk("d2_count_full", bus2.count,   2);
        chk("d2_a_ready",    bus2.a_ready, 1'b0);
        chk("d2_b_ready",    bus2.b_ready, 1'b0);
        chk("d2_head",       bus2.WriteAddr, 5'd1);
        step();
        chk("d2_count1",     bus2.count,   1);
        chk("d2_a_ready1",   bus2.a_ready, 1'b1);
        chk("d2_head2",      bus2.WriteData, 32'h2);
        step();
        chk("d2_empty",      bus2.empty,   1'b1);

        // Build count to 3 and probe the B credit rule.
        drive(1'b1, 5'd1, 32'h1, 32'h0, 1'b1, 5'd2, 32'h2, 32'h0);
        step();
        drive(1'b1, 5'd3, 32'h3, 32'h0, 1'b1, 5'd4, 32'h4, 32'h0);
        step();
        drive(1'b1, 5'd5, 32'h5, 32'h0, 1'b1, 5'd6, 32'h6, 32'h0);
        #1;
        chk("c3_count",   bus.count,   3);
        chk("c3_a_ready", bus.a_ready, 1'b1);
        chk("c3_b_ready", bus.b_ready, 1'b0);
        step();
        drive(1'b1, 5'd0, 32'h7, 32'h0, 1'b1, 5'd6, 32'h6, 32'h0);
        #1;
        chk("c3_b_ready_a0", bus.b_ready, 1'b1);
        step();
        idle();
        repeat (4) step();

        // Register 0 is accepted and dropped.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 32'h40, 1'b0, 5'd0, '0, '0);
        #1;
        chk("r0_a_ready", bus.a_ready, 1'b1);
        step();
        idle();
        chk("r0_RegWrite", bus.RegWrite, 1'b0);
        chk("r0_count",    bus.count,    0);

        // Lookup returns the youngest of two writes to $7.
        bus.q1_addr = 5'd7;
        bus.q2_addr = 5'd0;
        drive(1'b1, 5'd7, 32'h1, 32'h0, 1'b1, 5'd7, 32'h2, 32'h0);
        step();
        idle();
        #1;
        chk("fw_q1_hit",  bus.q1_hit,  FWD);
        chk("fw_q1_data", bus.q1_data, FWD ? 32'h2 : 32'h0);
        chk("fw_q2_hit",  bus.q2_hit,  1'b0);
        chk("fw_q2_data", bus.q2_data, 32'h0);
        step();
        chk("fw_head_q1_data", bus.q1_data, FWD ? 32'h2 : 32'h0);
        step();
        chk("fw_gone_q1_hit", bus.q1_hit, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom);
            bus.q1_addr = 5'($urandom_range(0, 7));
            bus.q2_addr = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        repeat (4) step();

        // Asynchronous reset mid-cycle with 3 entries queued.
        bus.q1_addr = 5'd3;
        drive(1'b1, 5'd1, 32'h1, 32'h0, 1'b1, 5'd2, 32'h2, 32'h0);
        step();
        drive(1'b1, 5'd3, 32'h3, 32'h0, 1'b1, 5'd4, 32'h4, 32'h0);
        step();
        idle();
        chk("ar_count_pre", bus.count, 3);
        #2;
        Reset = 1'b1;
        #1;
        mq.delete();
        chk("ar_RegWrite",  bus.RegWrite,  1'b0);
        chk("ar_count",     bus.count,     0);
        chk("ar_WriteAddr", bus.WriteAddr, 5'd0);
        chk("ar_q1_hit",    bus.q1_hit,    1'b0);
        chk("ar_a_ready",   bus.a_ready,   1'b1);
        drive(1'b1, 5'd9, 32'h9, 32'h0, 1'b1, 5'd10, 32'hA, 32'h0);
        #1;
        step();
        idle();
        Reset = 1'b0;
        repeat (3) step();
        chk("ar_no_stale", bus.RegWrite, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
